// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maze_pkg
// Description : Shared constants, state encoding and wall-index helpers for
//               the maze game controller.
//               COLS/ROWS     - maze dimensions in cells
//               H_BITS/V_BITS - widths of the horizontal / vertical wall maps
//               DIR_*         - move direction encoding
//               state_t       - controller state encoding
//               h_idx/v_idx   - bit index of a cell's north / west wall
// Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

    localparam int COLS   = 10;
    localparam int ROWS   = 15;
    localparam int H_BITS = (ROWS + 1) * COLS;   // 160
    localparam int V_BITS = ROWS * (COLS + 1);   // 165

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GEN_RST = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_GEN_RUN = 3'd3,
        ST_PLAY    = 3'd4,
        ST_WON     = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    // Bit of h_walls holding the wall above cell (x,y).
    function automatic logic [8:0] h_idx(input logic [3:0] x, input logic [3:0] y);
        return 9'(y) * 9'(COLS) + 9'(x);
    endfunction

    // Bit of v_walls holding the wall left of cell (x,y).
    function automatic logic [8:0] v_idx(input logic [3:0] x, input logic [3:0] y);
        return 9'(y) * 9'(COLS + 1) + 9'(x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : maze_lfsr
// Description : 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11.
//               A zero seed is replaced by 1 so the register never locks up.
// Ports       : clk      - clock
//               rst_n    - asynchronous active-low reset (loads seed)
//               i_en     - advance one step this cycle
//               o_state  - current 16-bit LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module maze_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    output logic [15:0] o_state
);

    localparam logic [15:0] c_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] c_TAPS = 16'hB400;

    logic [15:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_SEED;
        end else if (i_en) begin
            r_state <= (r_state >> 1) ^ (r_state[0] ? c_TAPS : 16'h0000);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/maze_game_controller.sv
`default_nettype none
// ============================================================================
// Module      : maze_game_controller
// Description : Sequences a maze generator (reset, random stream, completion
//               wait with timeout) and then arbitrates player moves against
//               the finished wall maps, tracking position and win.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               i_start         - request a new maze
//               o_gen_rst       - reset to generator
//               o_gen_rnd       - random byte to generator
//               i_gen_busy      - generator busy
//               i_h_walls       - horizontal wall map (wall above each cell)
//               i_v_walls       - vertical wall map (wall left of each cell)
//               i_move_valid    - move request
//               i_move_dir      - 0=N 1=E 2=S 3=W
//               o_move_ready    - move accepted this cycle if valid
//               o_move_done     - one-cycle result pulse of an accepted move
//               o_move_blocked  - with move_done: move hit a wall/border
//               o_player_x/y    - player position
//               o_maze_ready    - playing
//               o_win           - exit reached
//               o_gen_error     - generator timed out
// Revision    : 1.0 - initial release
// ============================================================================
module maze_game_controller
    import maze_pkg::*;
#(
    parameter int          EXIT_X         = 9,
    parameter int          EXIT_Y         = 14,
    parameter int          GEN_RST_CYCLES = 2,
    parameter int          SETTLE_CYCLES  = 2,
    parameter int          GEN_TIMEOUT    = 2047,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    output logic              o_gen_rst,
    output logic [7:0]        o_gen_rnd,
    input  logic              i_gen_busy,
    input  logic [H_BITS-1:0] i_h_walls,
    input  logic [V_BITS-1:0] i_v_walls,
    input  logic              i_move_valid,
    input  logic [1:0]        i_move_dir,
    output logic              o_move_ready,
    output logic              o_move_done,
    output logic              o_move_blocked,
    output logic [3:0]        o_player_x,
    output logic [3:0]        o_player_y,
    output logic              o_maze_ready,
    output logic              o_win,
    output logic              o_gen_error
);

    // ------------------------------------------------------------------
    // Random stream
    // ------------------------------------------------------------------
    logic [15:0] w_lfsr;
    logic [7:0]  w_lfsr_unused_hi;   // only the low byte is exported

    maze_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (1'b1),
        .o_state (w_lfsr)
    );

    assign o_gen_rnd        = w_lfsr[7:0];
    assign w_lfsr_unused_hi = w_lfsr[15:8];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_px;
    logic [3:0]  r_py;
    logic        r_done;
    logic        r_blk;
    logic        r_gen_rst;
    logic        r_maze_ready;
    logic        r_win;
    logic        r_gen_error;

    state_t      w_state_n;
    logic [15:0] w_cnt_n;
    logic [3:0]  w_px_n;
    logic [3:0]  w_py_n;
    logic        w_done_n;
    logic        w_blk_n;

    logic        w_move_ready;
    logic        w_accept;
    logic        w_at_exit;

    assign w_move_ready = (r_state == ST_PLAY) & ~i_start;
    assign w_accept     = i_move_valid & w_move_ready;
    assign w_at_exit    = (r_px == 4'(EXIT_X)) && (r_py == 4'(EXIT_Y));

    // ------------------------------------------------------------------
    // Move checker. Wall maps are zero-padded to 512 bits so the 9-bit
    // index addresses them exactly; real indices never exceed the map.
    // ------------------------------------------------------------------
    logic [511:0] w_h_pad;
    logic [511:0] w_v_pad;
    logic         w_blocked;
    logic [3:0]   w_nx;
    logic [3:0]   w_ny;

    assign w_h_pad = {{(512 - H_BITS){1'b0}}, i_h_walls};
    assign w_v_pad = {{(512 - V_BITS){1'b0}}, i_v_walls};

    always_comb begin
        w_blocked = 1'b1;
        w_nx      = r_px;
        w_ny      = r_py;
        case (i_move_dir)
            DIR_N: begin
                w_blocked = (r_py == 4'd0) | w_h_pad[h_idx(r_px, r_py)];
                w_ny      = r_py - 4'd1;
            end
            DIR_E: begin
                w_blocked = (r_px == 4'(COLS - 1)) | w_v_pad[v_idx(r_px + 4'd1, r_py)];
                w_nx      = r_px + 4'd1;
            end
            DIR_S: begin
                w_blocked = (r_py == 4'(ROWS - 1)) | w_h_pad[h_idx(r_px, r_py + 4'd1)];
                w_ny      = r_py + 4'd1;
            end
            default: begin
                w_blocked = (r_px == 4'd0) | w_v_pad[v_idx(r_px, r_py)];
                w_nx      = r_px - 4'd1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_px_n    = r_px;
        w_py_n    = r_py;
        w_done_n  = 1'b0;
        w_blk_n   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_n = ST_GEN_RST;
                    w_cnt_n   = '0;
                end
            end
            ST_GEN_RST: begin
                if (r_cnt == 16'(GEN_RST_CYCLES - 1)) begin
                    w_state_n = ST_SETTLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            ST_SETTLE: begin
                // Busy is not trusted until the generator has come out of reset.
                if (r_cnt == 16'(SETTLE_CYCLES - 1)) begin
                    w_state_n = ST_GEN_RUN;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            ST_GEN_RUN: begin
                if (!i_gen_busy) begin
                    w_state_n = ST_PLAY;
                    w_cnt_n   = '0;
                end else if (r_cnt == 16'(GEN_TIMEOUT - 1)) begin
                    w_state_n = ST_ERROR;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            ST_PLAY: begin
                if (i_start) begin
                    w_state_n = ST_GEN_RST;
                    w_cnt_n   = '0;
                    w_px_n    = '0;
                    w_py_n    = '0;
                end else begin
                    // Arrival is judged on the registered move result.
                    if (r_done && w_at_exit) begin
                        w_state_n = ST_WON;
                    end
                    if (w_accept) begin
                        w_done_n = 1'b1;
                        w_blk_n  = w_blocked;
                        if (!w_blocked) begin
                            w_px_n = w_nx;
                            w_py_n = w_ny;
                        end
                    end
                end
            end
            ST_WON, ST_ERROR: begin
                if (i_start) begin
                    w_state_n = ST_GEN_RST;
                    w_cnt_n   = '0;
                    w_px_n    = '0;
                    w_py_n    = '0;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and registered status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_done       <= 1'b0;
            r_blk        <= 1'b0;
            r_gen_rst    <= 1'b1;
            r_maze_ready <= 1'b0;
            r_win        <= 1'b0;
            r_gen_error  <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_px         <= w_px_n;
            r_py         <= w_py_n;
            r_done       <= w_done_n;
            r_blk        <= w_blk_n;
            r_gen_rst    <= (w_state_n == ST_IDLE) || (w_state_n == ST_GEN_RST);
            r_maze_ready <= (w_state_n == ST_PLAY);
            r_win        <= (w_state_n == ST_WON);
            r_gen_error  <= (w_state_n == ST_ERROR);
        end
    end

    assign o_gen_rst      = r_gen_rst;
    assign o_move_ready   = w_move_ready;
    assign o_move_done    = r_done;
    assign o_move_blocked = r_blk;
    assign o_player_x     = r_px;
    assign o_player_y     = r_py;
    assign o_maze_ready   = r_maze_ready;
    assign o_win          = r_win;
    assign o_gen_error    = r_gen_error;

endmodule
`default_nettype wire

// File: tb/tb_maze_game_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_maze_game_controller
// Description : Self-checking bench for maze_game_controller. A stub drives
//               gen_busy and the wall maps; a queue of expected move results
//               is popped by an independent monitor on every move_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_game_controller;
    import maze_pkg::*;

    localparam int          TIMEOUT = 2047;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          EX      = 9;
    localparam int          EY      = 14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              gen_busy = 1'b1;
    logic [H_BITS-1:0] h_walls = '0;
    logic [V_BITS-1:0] v_walls = '0;
    logic              move_valid = 1'b0;
    logic [1:0]        move_dir = 2'd0;

    logic       gen_rst, move_ready, move_done, move_blocked;
    logic       maze_ready, win, gen_error;
    logic [7:0] gen_rnd;
    logic [3:0] player_x, player_y;

    always #5 clk = ~clk;

    maze_game_controller #(
        .EXIT_X         (EX),
        .EXIT_Y         (EY),
        .GEN_RST_CYCLES (2),
        .SETTLE_CYCLES  (2),
        .GEN_TIMEOUT    (TIMEOUT),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .o_gen_rst      (gen_rst),
        .o_gen_rnd      (gen_rnd),
        .i_gen_busy     (gen_busy),
        .i_h_walls      (h_walls),
        .i_v_walls      (v_walls),
        .i_move_valid   (move_valid),
        .i_move_dir     (move_dir),
        .o_move_ready   (move_ready),
        .o_move_done    (move_done),
        .o_move_blocked (move_blocked),
        .o_player_x     (player_x),
        .o_player_y     (player_y),
        .o_maze_ready   (maze_ready),
        .o_win          (win),
        .o_gen_error    (gen_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit blk;
        int x;
        int y;
    } exp_t;

    exp_t sbq[$];
    int   mx, my;   // reference player position

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference Galois step for x^16+x^14+x^13+x^11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Reference wall rule straight from the cell/wall geometry.
    function automatic bit is_blocked(input int x, input int y, input int d);
        case (d)
            0:       return (y == 0)        || (h_walls[y * COLS + x] == 1'b1);
            1:       return (x == COLS - 1) || (v_walls[y * (COLS + 1) + x + 1] == 1'b1);
            2:       return (y == ROWS - 1) || (h_walls[(y + 1) * COLS + x] == 1'b1);
            default: return (x == 0)        || (v_walls[y * (COLS + 1) + x] == 1'b1);
        endcase
    endfunction

    // Drive one move for one cycle and queue its expected outcome.
    task automatic issue_move(input int d);
        exp_t e;
        move_valid = 1'b1;
        move_dir   = 2'(d);
        e.blk      = is_blocked(mx, my, d);
        if (!e.blk) begin
            case (d)
                0:       my = my - 1;
                1:       mx = mx + 1;
                2:       my = my + 1;
                default: mx = mx - 1;
            endcase
        end
        e.x = mx;
        e.y = my;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gen_rst"},      32'(gen_rst),      32'd1);
        check({tag, "_gen_rnd"},      32'(gen_rnd),      32'(SEED[7:0]));
        check({tag, "_move_ready"},   32'(move_ready),   32'd0);
        check({tag, "_move_done"},    32'(move_done),    32'd0);
        check({tag, "_move_blocked"}, 32'(move_blocked), 32'd0);
        check({tag, "_player_x"},     32'(player_x),     32'd0);
        check({tag, "_player_y"},     32'(player_y),     32'd0);
        check({tag, "_maze_ready"},   32'(maze_ready),   32'd0);
        check({tag, "_win"},          32'(win),          32'd0);
        check({tag, "_gen_error"},    32'(gen_error),    32'd0);
    endtask

    task automatic drain_check(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_pending_moves"}, 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    // Scoreboard monitor: every move_done pops one expectation.
    exp_t got;
    always @(negedge clk) begin
        if (rst_n && move_done) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_move_done: got move_done=1, expected no result at %0t", $time);
            end else begin
                got = sbq.pop_front();
                check("move_blocked", 32'(move_blocked), 32'(got.blk));
                check("move_player_x", 32'(player_x), 32'(got.x));
                check("move_player_y", 32'(player_y), 32'(got.y));
            end
        end
    end

    logic [15:0] m_lfsr;

    initial begin
        // ---------------- reset and idle ----------------
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n  = 1'b1;
        m_lfsr = SEED;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            m_lfsr = lfsr_step(m_lfsr);
            check("idle_gen_rnd", 32'(gen_rnd), 32'(m_lfsr[7:0]));
            if (i % 25 == 0) begin
                check("idle_gen_rst", 32'(gen_rst), 32'd1);
                check("idle_flags", {29'd0, maze_ready, win, gen_error}, 32'd0);
                check("idle_move_ready", 32'(move_ready), 32'd0);
            end
        end

        // ---------------- first generation, random walls ----------------
        for (int b = 0; b < H_BITS; b++) h_walls[b] = 1'($urandom_range(0, 1));
        for (int b = 0; b < V_BITS; b++) v_walls[b] = 1'($urandom_range(0, 1));
        v_walls[1] = 1'b0;
        gen_busy   = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            check("gen1_gen_rst", 32'(gen_rst), (i <= 2) ? 32'd1 : 32'd0);
            check("gen1_maze_ready_low", 32'(maze_ready), 32'd0);
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("gen1_busy_hold", 32'(maze_ready), 32'd0);
        gen_busy = 1'b0;
        @(negedge clk);
        check("gen1_maze_ready", 32'(maze_ready), 32'd1);
        check("gen1_player", {24'd0, player_x, player_y}, 32'd0);
        check("gen1_move_ready", 32'(move_ready), 32'd1);

        // ---------------- moves against random walls ----------------
        mx = 0;
        my = 0;
        issue_move(0);   // N at top border
        issue_move(3);   // W at left border
        issue_move(1);   // E through open v_walls[1]
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                move_valid = 1'b0;
                @(negedge clk);
            end else begin
                issue_move(int'($urandom_range(0, 3)));
            end
            if (mx == EX && my == EY) break;
        end
        move_valid = 1'b0;
        drain_check("rand");

        // ---------------- start masks move_ready; timeout ----------------
        gen_busy = 1'b1;
        start    = 1'b1;
        #1;
        check("start_masks_ready", 32'(move_ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("regen_player", {24'd0, player_x, player_y}, 32'd0);
        check("regen_maze_ready", 32'(maze_ready), 32'd0);
        // now one cycle after the start edge; error expected at cycle 2052
        for (int i = 1; i < 2051; i++) @(negedge clk);
        check("timeout_before", 32'(gen_error), 32'd0);
        @(negedge clk);
        check("timeout_error", 32'(gen_error), 32'd1);
        check("timeout_maze_ready", 32'(maze_ready), 32'd0);
        check("timeout_gen_rst", 32'(gen_rst), 32'd0);

        // ---------------- recovery; busy low during settle ----------------
        h_walls  = '0;
        v_walls  = '0;
        gen_busy = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            check("rec_gen_rst", 32'(gen_rst), (i <= 2) ? 32'd1 : 32'd0);
            check("rec_maze_ready", 32'(maze_ready), (i >= 6) ? 32'd1 : 32'd0);
            check("rec_gen_error", 32'(gen_error), 32'd0);
            if (i < 6) @(negedge clk);
        end

        // ---------------- open maze: walk to the exit ----------------
        mx = 0;
        my = 0;
        issue_move(0);
        issue_move(3);
        for (int i = 0; i < 9; i++) issue_move(1);
        issue_move(1);   // right border
        for (int i = 0; i < 14; i++) issue_move(2);
        move_valid = 1'b0;
        check("arrive_win_not_yet", 32'(win), 32'd0);
        @(negedge clk);
        check("win", 32'(win), 32'd1);
        check("win_move_ready", 32'(move_ready), 32'd0);
        check("win_maze_ready", 32'(maze_ready), 32'd0);
        check("win_player", {24'd0, player_x, player_y}, {24'd0, 4'(EX), 4'(EY)});
        drain_check("walk");

        // ---------------- async reset mid GEN_RUN ----------------
        gen_busy = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_genrun");
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- async reset mid PLAY ----------------
        gen_busy = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("play2_maze_ready", 32'(maze_ready), 32'd1);
        mx = 0;
        my = 0;
        issue_move(1);
        move_valid = 1'b0;
        drain_check("play2");
        check("play2_player_x", 32'(player_x), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_play");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_gen_rst", 32'(gen_rst), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
